uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver for 8N1 serial frames, LSB first. It is the receive-side partner of the team's uart_tx on the same serial link.
- Synchronises the asynchronous rxd line, detects the start bit and samples each bit at mid-bit.
- Delivers each byte on a parallel bus with a one-cycle done strobe.
- Feeds command parsers for the board's serial debug interface.

Parameters:
BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); must be >= 8.
CNT_W, $clog2(BAUD_DIV), width of the bit-period counter.

Ports:
Clk        input   1  system clock
Rst        input   1  reset, asynchronous, active-high
rxd        input   1  serial input, idles high, asynchronous to Clk
rx_data    output  8  last correctly framed byte
rx_done    output  1  one-cycle pulse, rx_data valid
frame_err  output  1  one-cycle pulse, stop bit sampled low
parity_err output  1  one-cycle pulse, parity mismatch (see Optional Feature)
rx_busy    output  1  high while a frame is in progress

Behaviour:
- Clocking and reset:
  - One clock (Clk).
  - Reset is asynchronous and active-high (Rst).
  - Reset values: rx_data=8'h00; rx_done=0; frame_err=0; parity_err=0; rx_busy=0; state=IDLE; counters=0; both sync flops=1.
- Synchroniser:
  - Two flops on rxd, reset to 1.
  - A third flop holds the previous synced value for edge detection.
  - Falling edge = previous synced value 1 and current synced value 0.
- State machine: IDLE, START, DATA, STOP (plus PARITY under the macro).
  - IDLE, falling edge detected -> START, cnt_bps=0, rx_busy=1.
  - START:
    - cnt_bps counts up each cycle.
    - At cnt_bps==BAUD_DIV/2-1, sample the synced line.
    - Sampled 0 -> DATA, cnt_bps=0, cnt_bit=0.
    - Sampled 1 -> glitch; go to IDLE with no pulse.
  - DATA:
    - At cnt_bps==BAUD_DIV-1: shift the sample into shift_reg[7] (right shift, so LSB first), cnt_bps=0, cnt_bit+1.
    - After the 8th sample -> STOP.
  - STOP, at cnt_bps==BAUD_DIV-1, sample the line:
    - Sampled 1 -> rx_data<=shift_reg and rx_done=1 on the same edge.
    - Sampled 0 -> frame_err=1; rx_data keeps its old value.
    - Either way: go to IDLE and clear rx_busy on the same edge.
- Pulse outputs: rx_done, frame_err and parity_err are high for exactly one cycle.
- Latency: let N be the edge on which the falling edge is detected (3rd Clk edge after rxd falls, ±1 from input phase).
  - Bit samples at N+BAUD_DIV/2+k*BAUD_DIV, for k=0 (start bit) through k=9 (stop bit).
  - rx_done is visible on the cycle after edge N+BAUD_DIV/2+9*BAUD_DIV.
  - With BAUD_DIV=434 this is 4126 cycles after rxd falls.
- Back-to-back frames: the stop sample is taken at mid-bit and IDLE is re-entered immediately. A start bit arriving BAUD_DIV/2 cycles later is caught with no lost frame.
- Break / stuck-low line:
  - One frame_err is generated.
  - IDLE then needs a new falling edge, so there is no retrigger while rxd stays low.
- rxd activity while busy: edges are ignored until the state returns to IDLE.
- Reset mid-frame: all state clears immediately, with no pulse output. The partial byte is discarded.
- Counter widths:
  - cnt_bps is CNT_W bits and never exceeds BAUD_DIV-1.
  - cnt_bit is 4 bits.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1 (11 bits).
  - After DATA, a PARITY state samples at BAUD_DIV-1 and compares the sample against ^shift_reg (even parity).
  - On mismatch, parity_err pulses on the stop-sample edge, together with rx_done or frame_err.
  - rx_data still updates if the stop bit is good.
  - rx_done moves one BAUD_DIV later than in 8N1.
- Not defined:
  - No PARITY state.
  - The parity_err port remains present and is tied to 0.

Test Plan:
- Reset then idle: Rst=1 for 5 cycles, rxd=1 for 10000 cycles -> all outputs 0, rx_busy=0.
- Single frame: drive 0xA5 8N1 at 434 cycles/bit -> exactly one rx_done, rx_data=8'hA5, 4126±1 cycles after rxd falls, frame_err=0.
- Back-to-back frames: drive 0x00, 0xFF, 0x3C with no idle gap -> three rx_done pulses with rx_data 00, FF, 3C in order.
- Glitch and bad stop:
  - 100-cycle low pulse on rxd -> no pulses, rx_busy falls about 220 cycles after the pulse begins.
  - Frame 0x55 with stop bit driven 0 -> frame_err pulse, rx_data unchanged.
- Reset mid-frame and break:
  - Assert Rst during bit 4 of 0x81, then send 0x42 -> only rx_done with 8'h42.
  - Hold rxd low for 20 bit times -> exactly one frame_err.
- Parity (with UART_RX_PARITY_EN):
  - 0x07 with parity bit 1 -> rx_done, parity_err=0.
  - Same byte with parity bit 0 -> rx_done with parity_err=1 in the same cycle.

Source files
------------

// File: rtl/uart_rx_if.sv
// Parallel side and serial input of the 8N1/8E1 UART receiver.
// The receiver takes the master modport; a command parser takes the slave modport.
`default_nettype none

interface uart_rx_if;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    modport master (
        input  rxd,
        output rx_data, rx_done, frame_err, parity_err, rx_busy
    );

    modport slave (
        output rxd,
        input  rx_data, rx_done, frame_err, parity_err, rx_busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, LSB first, mid-bit sampling of a synchronised rxd.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check (parity_err).
`default_nettype none

module uart_rx #(
    parameter int BAUD_DIV = 434,
    parameter int CNT_W    = $clog2(BAUD_DIV)
) (
    input  logic     Clk,
    input  logic     Rst,
    uart_rx_if.master bus
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV/2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt_bps;
    logic [3:0]       cnt_bit;
    logic [7:0]       shift_reg;
    logic [7:0]       rx_data_q;
    logic             rx_done_q;
    logic             frame_err_q;
    logic             rx_busy_q;

    // Two-flop synchroniser plus one history flop; all reset to the idle level
    logic rxd_s1, rxd_s2, rxd_prev;
    logic fall;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= bus.rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    assign fall = rxd_prev & ~rxd_s2;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic parity_err_q;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            cnt_bps     <= '0;
            cnt_bit     <= '0;
            shift_reg   <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Requires a fresh 1->0 transition, so a stuck-low line never retriggers
                    if (fall) begin
                        state     <= START;
                        cnt_bps   <= '0;
                        rx_busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_bps == HALF_M1) begin
                        cnt_bps <= '0;
                        if (!rxd_s2) begin
                            state   <= DATA;
                            cnt_bit <= '0;
                        end else begin
                            state     <= IDLE;
                            rx_busy_q <= 1'b0;
                        end
                    end else begin
                        cnt_bps <= cnt_bps + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_bps == FULL_M1) begin
                        cnt_bps   <= '0;
                        shift_reg <= {rxd_s2, shift_reg[7:1]};
                        cnt_bit   <= cnt_bit + 4'd1;
                        if (cnt_bit == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt_bps <= cnt_bps + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_bps == FULL_M1) begin
                        cnt_bps <= '0;
                        par_bad <= rxd_s2 ^ (^shift_reg);
                        state   <= STOP;
                    end else begin
                        cnt_bps <= cnt_bps + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop so a back-to-back start bit is never missed
                    if (cnt_bps == FULL_M1) begin
                        cnt_bps   <= '0;
                        state     <= IDLE;
                        rx_busy_q <= 1'b0;
                        if (rxd_s2) begin
                            rx_data_q <= shift_reg;
                            rx_done_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad;
`endif
                    end else begin
                        cnt_bps <= cnt_bps + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt_bps   <= '0;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = rx_busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: random and directed frames, expected events queued
// by the stimulus and popped by a monitor whenever the receiver pulses an output.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int BD = 434;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // rxd falls just after a clock edge: 3 edges to detect, half a bit, then the rest of the frame
    localparam int LAT = 3 + BD/2 + (NBITS-1)*BD;

    logic Clk;
    logic Rst;
    int   cyc;
    bit   stim_end;

    uart_rx_if u_if();

    uart_rx #(.BAUD_DIV(BD)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (u_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic       good;    // 1: rx_done expected, 0: frame_err expected
        logic [7:0] data;    // rx_data expected alongside the pulse
        logic       perr;
        int         fall;
    } exp_t;

    typedef struct {
        int    at;
        int    sig;          // 0 busy, 1 rx_data, 2 rx_done, 3 frame_err, 4 parity_err
        int    val;
        string name;
    } chk_t;

    exp_t       exp_q[$];
    chk_t       chk_q[$];
    logic [7:0] last_good;
    int         n_cmp;
    int         n_fail;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push_chk(input int at, input int sig, input int val, input string name);
        chk_t c;
        c.at = at; c.sig = sig; c.val = val; c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic push_quiet(input int at, input logic [7:0] data, input string name);
        push_chk(at, 0, 0, {name, "_busy"});
        push_chk(at, 1, int'(data), {name, "_data"});
        push_chk(at, 2, 0, {name, "_done"});
        push_chk(at, 3, 0, {name, "_ferr"});
        push_chk(at, 4, 0, {name, "_perr"});
    endtask

    function automatic logic even_bit(input logic [7:0] d);
        return logic'($countones(d) % 2);
    endfunction

    // Reference: the frame's meaning follows from the bits put on the wire
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
        exp_t e;
        e.good = sbit;
`ifdef UART_RX_PARITY_EN
        e.perr = logic'(($countones(d) + int'(pbit)) % 2);
`else
        e.perr = 1'b0;
`endif
        if (sbit) last_good = d;
        e.data = last_good;
        e.fall = cyc;
        exp_q.push_back(e);
        u_if.rxd = 1'b0;
        wait_cyc(BD);
        for (int i = 0; i < 8; i++) begin
            u_if.rxd = d[i];
            wait_cyc(BD);
        end
`ifdef UART_RX_PARITY_EN
        u_if.rxd = pbit;
        wait_cyc(BD);
`endif
        u_if.rxd = sbit;
        wait_cyc(BD);
        u_if.rxd = 1'b1;
    endtask

    // Stimulus
    initial begin
        logic [7:0] d;
        logic       pb, sb;
        int         c0;
        exp_t       e;
        stim_end  = 1'b0;
        last_good = 8'h00;
        Rst       = 1'b1;
        u_if.rxd  = 1'b1;
        wait_cyc(3);
        push_quiet(cyc + 1, 8'h00, "reset");
        wait_cyc(2);
        Rst = 1'b0;

        wait_cyc(10000);
        push_quiet(cyc, 8'h00, "idle");
        wait_cyc(2);

        d = 8'hA5; send_frame(d, even_bit(d), 1'b1);
        wait_cyc(BD);

        d = 8'h00; send_frame(d, even_bit(d), 1'b1);
        d = 8'hFF; send_frame(d, even_bit(d), 1'b1);
        d = 8'h3C; send_frame(d, even_bit(d), 1'b1);
        wait_cyc(BD);

        // 100-cycle glitch: rejected at the start-bit mid-sample
        c0 = cyc;
        push_chk(c0 + BD/2 + 1, 0, 1, "glitch_busy_hi");
        push_chk(c0 + BD/2 + 5, 0, 0, "glitch_busy_lo");
        u_if.rxd = 1'b0;
        wait_cyc(100);
        u_if.rxd = 1'b1;
        wait_cyc(BD);

        d = 8'h55; send_frame(d, even_bit(d), 1'b0);
        wait_cyc(2*BD);

        // Reset in the middle of bit 4 of 0x81 discards the frame
        d = 8'h81;
        u_if.rxd = 1'b0;
        wait_cyc(BD);
        for (int i = 0; i < 4; i++) begin
            u_if.rxd = d[i];
            wait_cyc(BD);
        end
        u_if.rxd = d[4];
        wait_cyc(BD/2);
        Rst = 1'b1;
        u_if.rxd = 1'b1;
        last_good = 8'h00;
        push_quiet(cyc + 1, 8'h00, "midreset");
        wait_cyc(5);
        Rst = 1'b0;
        wait_cyc(2*BD);
        d = 8'h42; send_frame(d, even_bit(d), 1'b1);
        wait_cyc(BD);

        // Break: 20 bit times low gives exactly one frame_err
        e.good = 1'b0; e.data = last_good; e.perr = 1'b0; e.fall = cyc;
        exp_q.push_back(e);
        push_chk(cyc + 15*BD, 0, 0, "break_no_retrigger");
        u_if.rxd = 1'b0;
        wait_cyc(20*BD);
        u_if.rxd = 1'b1;
        wait_cyc(2*BD);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cyc(BD);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_cyc(BD);
`endif

        for (int n = 0; n < 4; n++) begin
            d  = 8'($urandom);
            pb = even_bit(d) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 3) != 0);
            send_frame(d, pb, sb);
            if (!sb) wait_cyc(2*BD);
            else     wait_cyc($urandom_range(0, BD));
        end

        wait_cyc(2*BD);
        push_quiet(cyc, last_good, "final");
        wait_cyc(2);
        stim_end = 1'b1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge
    initial begin
        chk_t c;
        exp_t e;
        int   act;
        int   lat;
        n_cmp  = 0;
        n_fail = 0;
        forever begin
            @(negedge Clk);
            while (chk_q.size() > 0 && chk_q[0].at <= cyc) begin
                c = chk_q.pop_front();
                case (c.sig)
                    0:       act = int'(u_if.rx_busy);
                    1:       act = int'(u_if.rx_data);
                    2:       act = int'(u_if.rx_done);
                    3:       act = int'(u_if.frame_err);
                    default: act = int'(u_if.parity_err);
                endcase
                chk(c.name, act, c.val);
            end
            if (u_if.rx_done || u_if.frame_err || u_if.parity_err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: done=%0b ferr=%0b perr=%0b data=%02h expected no pulse (cycle %0d)",
                             u_if.rx_done, u_if.frame_err, u_if.parity_err, u_if.rx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_done", int'(u_if.rx_done), int'(e.good));
                    chk("frame_err", int'(u_if.frame_err), int'(!e.good));
                    chk("rx_data", int'(u_if.rx_data), int'(e.data));
                    chk("parity_err", int'(u_if.parity_err), int'(e.perr));
                    lat = cyc - e.fall;
                    n_cmp++;
                    if (lat < LAT - 1 || lat > LAT + 1) begin
                        n_fail++;
                        $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, LAT);
                    end
                end
            end
            if (stim_end) begin
                chk("missing_pulses", exp_q.size(), 0);
                chk("unchecked_points", chk_q.size(), 0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
        end
    end

endmodule
